// File: rtl/processor_multicycle.sv
// processor_multicycle: multi-cycle RV32I-subset core.
// One shared ALU/regfile; unified req/ready memory port.
module processor_multicycle #(
  parameter int unsigned          BUS_WIDTH      = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned          REG_ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 instr_retired,
  output logic                 halted,
  output logic [BUS_WIDTH-1:0] pc_dbg
);
  localparam int unsigned W = BUS_WIDTH;
  localparam logic [W-1:0] FOUR = W'(4);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t state, state_n;

  logic [W-1:0] pc, old_pc, mdr, a, b, alu_out;
  logic [31:0]  ir;
  logic [W-1:0] rf [2**REG_ADDR_WIDTH];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [W-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [W-1:0] rs1_val, rs2_val;
  logic is_lw, is_sw, is_r, is_i, is_beq, is_jal;
  logic op_ok;
  logic [2:0] op_ctrl;

  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_ctrl;
  logic         slt;

  logic req, addr_alu, retire;
  logic ir_we, mdr_we, ab_we, aluout_we;
  logic pc_we, pc_from_aluout, rf_we;
  logic [W-1:0] rf_wdata, pc_next;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[7 +: REG_ADDR_WIDTH];
  assign rs1    = ir[15 +: REG_ADDR_WIDTH];
  assign rs2    = ir[20 +: REG_ADDR_WIDTH];

  assign imm_i = {{(W-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(W-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(W-13){ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(W-21){ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign is_lw  = (opcode == 7'b0000011);
  assign is_sw  = (opcode == 7'b0100011);
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_beq = (opcode == 7'b1100011);
  assign is_jal = (opcode == 7'b1101111);

  assign rs1_val = (rs1 == '0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf[rs2];

  // funct3/funct7 to ALU op; flags combinations the core cannot execute
  always_comb begin
    op_ok   = 1'b1;
    op_ctrl = ALU_ADD;
    unique case (funct3)
      3'b000:  op_ctrl = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  op_ctrl = ALU_AND;
      3'b110:  op_ctrl = ALU_OR;
      3'b010:  op_ctrl = ALU_SLT;
      default: op_ok = 1'b0;
    endcase
    if (is_r && funct7 != 7'h00 &&
        !(funct7 == 7'h20 && funct3 == 3'b000))
      op_ok = 1'b0;
  end

  assign slt = $signed(alu_a) < $signed(alu_b);

  // shared ALU
  always_comb begin
    unique case (alu_ctrl)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {{(W-1){1'b0}}, slt};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_n = S_MEMADR;
          is_r:    state_n = op_ok ? S_EXEC_R : S_HALT;
          is_i:    state_n = op_ok ? S_EXEC_I : S_HALT;
          is_beq:  state_n = S_BEQ;
          is_jal:  state_n = S_JAL;
          default: state_n = S_HALT;
        endcase
      end
      S_MEMADR: begin
        if (alu_y[1:0] != 2'b00) state_n = S_HALT;
        else if (is_lw)          state_n = S_MEMREAD;
        else                     state_n = S_MEMWRITE;
      end
      S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:   state_n = S_ALUWB;
      S_ALUWB,
      S_BEQ,
      S_JAL:      state_n = S_FETCH;
      default:    state_n = S_HALT;
    endcase
  end

  // per-state datapath controls
  always_comb begin
    req            = 1'b0;
    mem_we         = 1'b0;
    addr_alu       = 1'b0;
    ir_we          = 1'b0;
    mdr_we         = 1'b0;
    ab_we          = 1'b0;
    aluout_we      = 1'b0;
    pc_we          = 1'b0;
    pc_from_aluout = 1'b0;
    rf_we          = 1'b0;
    rf_wdata       = alu_out;
    retire         = 1'b0;
    alu_a          = pc;
    alu_b          = FOUR;
    alu_ctrl       = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        req   = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
      end
      S_DECODE: begin
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        alu_a     = old_pc;
        alu_b     = imm_b;
      end
      S_MEMADR: begin
        aluout_we = 1'b1;
        alu_a     = a;
        alu_b     = is_sw ? imm_s : imm_i;
      end
      S_MEMREAD: begin
        req      = 1'b1;
        addr_alu = 1'b1;
        mdr_we   = mem_ready;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
        retire   = 1'b1;
      end
      S_MEMWRITE: begin
        req      = 1'b1;
        mem_we   = 1'b1;
        addr_alu = 1'b1;
        retire   = mem_ready;
      end
      S_EXEC_R: begin
        aluout_we = 1'b1;
        alu_a     = a;
        alu_b     = b;
        alu_ctrl  = op_ctrl;
      end
      S_EXEC_I: begin
        aluout_we = 1'b1;
        alu_a     = a;
        alu_b     = imm_i;
        alu_ctrl  = op_ctrl;
      end
      S_ALUWB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_BEQ: begin
        pc_we          = (a == b);
        pc_from_aluout = 1'b1;
        retire         = 1'b1;
      end
      S_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = old_pc + FOUR;
        pc_we    = 1'b1;
        alu_a    = old_pc;
        alu_b    = imm_j;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_next = pc_from_aluout ? alu_out : alu_y;

  // architectural and holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (ir_we) begin
        ir     <= mem_rdata[31:0];
        old_pc <= pc;
      end
      if (pc_we)     pc      <= pc_next;
      if (mdr_we)    mdr     <= mem_rdata;
      if (ab_we) begin
        a <= rs1_val;
        b <= rs2_val;
      end
      if (aluout_we) alu_out <= alu_y;
    end
  end

  // register file write; x0 stays zero
  always_ff @(posedge clk) begin
    if (rst_n && rf_we && rd != '0)
      rf[rd] <= rf_wdata;
  end

  assign mem_req       = rst_n & req;
  assign mem_addr      = addr_alu ? alu_out : pc;
  assign mem_wdata     = b;
  assign instr_retired = rst_n & retire;
  assign halted        = (state == S_HALT);
  assign pc_dbg        = pc;

endmodule

// File: tb/tb_processor_multicycle.sv
// tb_processor_multicycle: directed tests for the
// multi-cycle core with a wait-state memory model.
module tb_processor_multicycle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        instr_retired, halted;
  logic [31:0] pc_dbg;

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;

  logic [31:0] mem [256];
  int wait_n = 0, wcnt = 0, stab_err = 0;
  logic p_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  processor_multicycle #(
    .BUS_WIDTH(32), .RESET_PC(32'h0), .REG_ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr_retired(instr_retired), .halted(halted),
    .pc_dbg(pc_dbg)
  );

  // memory: wait_n idle cycles, then ready for one cycle
  always @(negedge clk) begin
    if (mem_req && p_req && !mem_ready)
      if (mem_addr !== p_addr || mem_wdata !== p_wdata ||
          mem_we !== p_we)
        stab_err++;
    if (mem_ready || !mem_req) wcnt = 0;
    mem_ready = 1'b0;
    if (mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end else begin
        wcnt++;
      end
    end
    p_req   = mem_req;
    p_we    = mem_we;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
  end

  function automatic logic [31:0] enc_i(
    input logic [31:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [31:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [31:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] nop();
    return enc_i(32'd0, 5'd0, 3'b000, 5'd0, OP_I);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset(input int w);
    wait_n = w;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int n, input int budget,
                     output int tot, output int last);
    int r, c, lc;
    r = 0; c = 0; lc = 0; last = 0;
    while (r < n && c < budget) begin
      @(negedge clk); #1;
      c++; lc++;
      if (instr_retired) begin
        r++; last = lc; lc = 0;
      end
    end
    tot = c;
    checks++;
    if (r !== n)
      $display("FAIL run_timeout: retired %0d want %0d", r, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (pc_dbg !== 32'h0)
      $display("FAIL reset_pc: got %h want 0", pc_dbg);
    else passed++;
    checks++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted: got %b want 0", halted);
    else passed++;
    checks++;
    if (mem_req !== 1'b0)
      $display("FAIL reset_req: got %b want 0", mem_req);
    else passed++;
    checks++;
    if (instr_retired !== 1'b0)
      $display("FAIL reset_retire: got %b want 0", instr_retired);
    else passed++;
  endtask

  task automatic test_alu();
    int tot, last;
    clear_mem();
    mem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(32'd7, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    do_reset(0);
    run(3, 60, tot, last);
    @(posedge clk); #1;
    checks++;
    if (tot !== 12)
      $display("FAIL alu_cycles: got %0d want 12", tot);
    else passed++;
    checks++;
    if (dut.rf[3] !== 32'd12)
      $display("FAIL alu_x3: got %h want 12", dut.rf[3]);
    else passed++;
    checks++;
    if (dut.rf[1] !== 32'd5 || dut.rf[2] !== 32'd7)
      $display("FAIL alu_x1x2: got %h %h want 5 7",
               dut.rf[1], dut.rf[2]);
    else passed++;
    checks++;
    if (pc_dbg !== 32'h0C)
      $display("FAIL alu_pc: got %h want c", pc_dbg);
    else passed++;
  endtask

  task automatic test_alu_ops();
    int tot, last;
    logic [31:0] exp [11];
    clear_mem();
    mem[0] = enc_i(32'd6, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd4);
    mem[4] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd5);
    mem[5] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6);
    mem[6] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd7);
    mem[7] = enc_i(32'd3, 5'd1, 3'b111, 5'd8, OP_I);
    mem[8] = enc_i(32'd1, 5'd1, 3'b110, 5'd9, OP_I);
    mem[9] = enc_i(32'hFFFF_FFFE, 5'd2, 3'b010, 5'd10, OP_I);
    exp[3] = 32'd9;  exp[4] = 32'd4;  exp[5] = 32'hFFFF_FFFF;
    exp[6] = 32'd0;  exp[7] = 32'd1;  exp[8] = 32'd2;
    exp[9] = 32'd7;  exp[10] = 32'd1;
    do_reset(0);
    run(10, 100, tot, last);
    @(posedge clk); #1;
    for (int r = 3; r <= 10; r++) begin
      checks++;
      if (dut.rf[r] !== exp[r])
        $display("FAIL ops_x%0d: got %h want %h",
                 r, dut.rf[r], exp[r]);
      else passed++;
    end
  endtask

  task automatic test_mem_wait();
    int tot, last;
    clear_mem();
    mem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(32'd7, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_s(32'd8, 5'd3, 5'd0);
    mem[4] = enc_i(32'd8, 5'd0, 3'b010, 5'd4, OP_LW);
    do_reset(3);
    stab_err = 0;
    run(5, 200, tot, last);
    @(posedge clk); #1;
    checks++;
    if (tot !== 42)
      $display("FAIL wait_cycles: got %0d want 42", tot);
    else passed++;
    checks++;
    if (mem[2] !== 32'd12)
      $display("FAIL sw_mem8: got %h want 12", mem[2]);
    else passed++;
    checks++;
    if (dut.rf[4] !== 32'd12)
      $display("FAIL lw_x4: got %h want 12", dut.rf[4]);
    else passed++;
    checks++;
    if (stab_err !== 0)
      $display("FAIL req_stable: got %0d changes want 0", stab_err);
    else passed++;
  endtask

  task automatic test_beq(input logic taken);
    int tot, last;
    logic [31:0] want;
    clear_mem();
    mem[0] = enc_i(32'd3, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(32'd4, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2] = nop();
    mem[3] = nop();
    mem[4] = enc_b(32'hFFFF_FFF8, taken ? 5'd1 : 5'd2, 5'd1);
    want = taken ? 32'h08 : 32'h14;
    do_reset(0);
    run(5, 80, tot, last);
    @(posedge clk); #1;
    checks++;
    if (last !== 3 || tot !== 19)
      $display("FAIL beq%0b_cycles: got %0d/%0d want 3/19",
               taken, last, tot);
    else passed++;
    checks++;
    if (pc_dbg !== want)
      $display("FAIL beq%0b_pc: got %h want %h",
               taken, pc_dbg, want);
    else passed++;
  endtask

  task automatic test_jal();
    int tot, last;
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = nop();
    mem[8]  = enc_j(32'h100, 5'd5);
    mem[72] = enc_i(32'd9, 5'd0, 3'b000, 5'd0, OP_I);
    mem[73] = enc_i(32'd1, 5'd0, 3'b000, 5'd6, OP_I);
    do_reset(0);
    run(9, 80, tot, last);
    @(posedge clk); #1;
    checks++;
    if (last !== 3 || tot !== 35)
      $display("FAIL jal_cycles: got %0d/%0d want 3/35", last, tot);
    else passed++;
    checks++;
    if (dut.rf[5] !== 32'h24)
      $display("FAIL jal_x5: got %h want 24", dut.rf[5]);
    else passed++;
    checks++;
    if (pc_dbg !== 32'h120)
      $display("FAIL jal_pc: got %h want 120", pc_dbg);
    else passed++;
    run(2, 30, tot, last);
    @(posedge clk); #1;
    checks++;
    if (dut.rf[0] !== 32'd0 || dut.rf[6] !== 32'd1)
      $display("FAIL x0_zero: got x0=%h x6=%h want 0 1",
               dut.rf[0], dut.rf[6]);
    else passed++;
  endtask

  task automatic test_halt();
    int tot, last, viol;
    clear_mem();
    mem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(32'd2, 5'd0, 3'b010, 5'd1, OP_LW);
    do_reset(0);
    run(1, 20, tot, last);
    repeat (4) @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1)
      $display("FAIL misalign_halt: got %b want 1", halted);
    else passed++;
    viol = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (mem_req || instr_retired || !halted) viol++;
    end
    checks++;
    if (viol !== 0)
      $display("FAIL halt_quiet: got %0d bad cycles want 0", viol);
    else passed++;
    checks++;
    if (dut.rf[1] !== 32'd5 || pc_dbg !== 32'h8)
      $display("FAIL halt_state: got x1=%h pc=%h want 5 8",
               dut.rf[1], pc_dbg);
    else passed++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pc_dbg !== 32'h0 || halted !== 1'b0)
      $display("FAIL halt_reset: got pc=%h h=%b want 0 0",
               pc_dbg, halted);
    else passed++;
    clear_mem();
    mem[0] = 32'h0000_007F;
    rst_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1 || pc_dbg !== 32'h4)
      $display("FAIL opc7f_halt: got h=%b pc=%h want 1 4",
               halted, pc_dbg);
    else passed++;
    clear_mem();
    mem[0] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3);
    do_reset(0);
    repeat (4) @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1)
      $display("FAIL rfunct_halt: got %b want 1", halted);
    else passed++;
  endtask

  task automatic test_reset_wait();
    int tot, last;
    clear_mem();
    mem[0] = enc_i(32'd1, 5'd0, 3'b000, 5'd7, OP_I);
    mem[1] = enc_i(32'd2, 5'd0, 3'b000, 5'd8, OP_I);
    do_reset(3);
    run(1, 40, tot, last);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_ready !== 1'b0)
      $display("FAIL wait_fetch: got req=%b a=%h rdy=%b want 1 4 0",
               mem_req, mem_addr, mem_ready);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0)
      $display("FAIL rst_gate: got %b want 0", mem_req);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || pc_dbg !== 32'h0)
      $display("FAIL rst_mid: got req=%b pc=%h want 0 0",
               mem_req, pc_dbg);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0)
      $display("FAIL refetch: got req=%b a=%h want 1 0",
               mem_req, mem_addr);
    else passed++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_alu();
    test_alu_ops();
    test_mem_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_halt();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
